// File: rtl/pulse_accumulator_if.sv
// ---------------------------------------------------------------------------
// pulse_accumulator_if
//   Bundles the request pulses and the accumulator outputs of
//   pulse_accumulator so the block and its driver share one port list.
//
//   inc, dec, clr : one-shot requests from the debouncers (master -> slave)
//   acc_out       : current accumulator value
//   acc_valid     : one-cycle strobe, acc_out changed
//   at_max/at_min : acc_out at all-ones / zero
//   ovf           : sticky wrap/clamp flag
//   state_dbg     : update FSM state (0 IDLE, 1 APPLY, 2 STROBE)
//
//   Handshake: there is no back-pressure. A request is taken on its rising
//   edge only; acc_valid is a qualifier the consumer samples once per change.
// ---------------------------------------------------------------------------
interface pulse_accumulator_if #(
    parameter int WIDTH = 8
);
    logic             inc;
    logic             dec;
    logic             clr;
    logic [WIDTH-1:0] acc_out;
    logic             acc_valid;
    logic             at_max;
    logic             at_min;
    logic             ovf;
    logic [1:0]       state_dbg;

    modport master (
        output inc, dec, clr,
        input  acc_out, acc_valid, at_max, at_min, ovf, state_dbg
    );

    modport slave (
        input  inc, dec, clr,
        output acc_out, acc_valid, at_max, at_min, ovf, state_dbg
    );
endinterface

// File: rtl/pulse_accumulator.sv
// ---------------------------------------------------------------------------
// pulse_accumulator
//   Up/down accumulator driven by debounced one-shot pulses. Rising edges of
//   inc/dec/clr add STEP, subtract STEP or zero the count. Boundary hits set
//   a sticky ovf flag; every change of the count is announced by a one-cycle
//   acc_valid strobe.
//
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : pulse_accumulator_if.slave (inc/dec/clr in, acc_out, acc_valid,
//         at_max, at_min, ovf, state_dbg out)
// ---------------------------------------------------------------------------
module pulse_accumulator #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int SATURATE = 1
) (
    input  logic                clk,
    input  logic                rst,
    pulse_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        STROBE = 2'd2
    } state_t;

    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_V  = '1;

    // Request vectors are ordered {clr, dec, inc}.
    logic [2:0]       cap_cur;
    logic [2:0]       cap_dly;
    logic [2:0]       edges;
    logic [2:0]       pend;
    logic [2:0]       req;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             ovf_q;
    logic             valid_q;
    logic             changed_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nxt_acc;
    logic             nxt_ovf;

    // Stage 1: capture plus delayed copy; a held request yields one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_cur <= '0;
            cap_dly <= '0;
        end else begin
            cap_cur <= {bus.clr, bus.dec, bus.inc};
            cap_dly <= cap_cur;
        end
    end

    assign edges = cap_cur & ~cap_dly;
    // IDLE services live edges together with anything parked while busy.
    assign req   = edges | pend;

    // Next value in WIDTH+1 bits: sum[WIDTH] is the carry out of an
    // increment, diff[WIDTH] is the borrow of a decrement (acc < STEP).
    always_comb begin
        sum     = {1'b0, acc} + STEP_X;
        diff    = {1'b0, acc} - STEP_X;
        nxt_acc = acc;
        nxt_ovf = ovf_q;
        if (req[2]) begin
            nxt_acc = '0;
            nxt_ovf = 1'b0;
        end else if (req[0] && !req[1]) begin
            if (sum[WIDTH]) begin
                nxt_ovf = 1'b1;
                nxt_acc = (SATURATE != 0) ? MAX_V : sum[WIDTH-1:0];
            end else begin
                nxt_acc = sum[WIDTH-1:0];
            end
        end else if (req[1] && !req[0]) begin
            if (diff[WIDTH]) begin
                nxt_ovf = 1'b1;
                nxt_acc = (SATURATE != 0) ? '0 : diff[WIDTH-1:0];
            end else begin
                nxt_acc = diff[WIDTH-1:0];
            end
        end
        // inc together with dec (no clr) falls through: both consumed, no change.
    end

    // Stage 2 update FSM. The write happens on the edge that enters APPLY so
    // the count lands one edge after the request is captured; APPLY then
    // decides whether a strobe follows. Edges arriving while APPLY/STROBE
    // are OR-ed into pend, so a repeat of a kind already parked is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            pend      <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        acc       <= nxt_acc;
                        ovf_q     <= nxt_ovf;
                        changed_q <= (nxt_acc != acc);
                        pend      <= '0;
                        state     <= APPLY;
                    end
                end
                APPLY: begin
                    pend <= pend | edges;
                    if (changed_q) begin
                        valid_q <= 1'b1;
                        state   <= STROBE;
                    end else begin
                        state   <= IDLE;
                    end
                end
                STROBE: begin
                    pend  <= pend | edges;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.acc_out   = acc;
    assign bus.acc_valid = valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.at_max    = (acc == MAX_V);
    assign bus.at_min    = (acc == '0);
    assign bus.state_dbg = state;

endmodule

// File: doc/pulse_accumulator.md
# pulse_accumulator

Up/down accumulator fed by debounced one-shot pulses from up to three push-button debouncers (increment, decrement, clear). Each qualifying pulse adds or subtracts a fixed step from a registered count. The block flags boundary hits and emits a one-cycle strobe whenever the value changes. It sits directly downstream of the debouncers and drives the display/compare logic of the accumulator design.

## Interface
- `WIDTH`, 8: accumulator width in bits (unsigned).
- `STEP`, 1: magnitude added or subtracted per event; must satisfy 1 ≤ STEP < 2^WIDTH.
- `SATURATE`, 1: 1 = clamp at 0 and 2^WIDTH−1; 0 = modulo-2^WIDTH wrap.

Ports:
- `clk`  in  1  system clock (50 MHz); one clock, all logic on rising edge.
- `rst`  in  1  reset is asynchronous and active-low.
- `inc`  in  1  increment request (one-shot from debouncer).
- `dec`  in  1  decrement request.
- `clr`  in  1  clear request; zeroes count and sticky flag.
- `acc_out`  out  WIDTH  current accumulator value.
- `acc_valid`  out  1  one-cycle strobe: acc_out changed this cycle.
- `at_max`  out  1  acc_out == 2^WIDTH−1 (combinational from acc_out register).
- `at_min`  out  1  acc_out == 0.
- `ovf`  out  1  sticky: set on any wrap or saturation-clamp event; cleared only by clr or reset.

## Operation
- Stage 1 (capture): registers inc/dec/clr each cycle plus one-cycle-delayed copies. An event is a rising edge (current 1, delayed 0). A request held high for many cycles counts once.
- Stage 2 (update) state machine, states IDLE, APPLY, STROBE:
  - IDLE: waits for any event. Moves to APPLY with the decoded operation latched.
  - APPLY: writes acc_out and updates ovf. Moves to STROBE if the value changed, else to IDLE.
  - STROBE: drives acc_valid=1 for exactly one cycle, then returns to IDLE.
  - Events detected in APPLY/STROBE are held in a one-deep pending register, one slot per kind. They are serviced from IDLE on the next cycle. A second edge of the same kind while its pending slot is full is dropped.
- Priority when events coincide (same cycle or pending together):
  - clr beats everything.
  - inc together with dec: both consumed; no change, no strobe, ovf untouched.
- Arithmetic: computed in WIDTH+1 bits.
  - inc: sum > 2^WIDTH−1 → SATURATE=1 clamps to max; SATURATE=0 keeps the low WIDTH bits. Either case sets ovf.
  - dec: acc < STEP → SATURATE=1 clamps to 0; SATURATE=0 wraps modulo 2^WIDTH. Either case sets ovf.
  - Clamp with no value change (already at max/min): ovf set, no strobe.
- clr: acc_out←0, ovf←0. Strobe only if acc_out was nonzero.
- Reset values: acc_out=0, acc_valid=0, ovf=0, at_min=1, at_max=0, state=IDLE, pending and capture registers cleared.

## Timing
- Let the rising edge where stage 1 first samples a request at 1 be edge k.
  - Edge k+1: acc_out and ovf take their new values.
  - Edge k+2: acc_valid rises; it falls at edge k+3.
- Minimum spacing for back-to-back processed events: 3 cycles. Closer events queue through the pending slots.
- Reset asserted mid-operation clears all state immediately (asynchronously). Any in-flight or pending event is discarded.
- Deassertion is synchronized externally; the first event is sampled on the first edge after rst rises.
- at_max and at_min change in the same cycle as acc_out.

## Test plan
- Reset, then a single inc pulse (WIDTH=8, STEP=1, SATURATE=1) → acc_out=1 after edge k+1; acc_valid high for one cycle at k+2; ovf=0, at_min=0.
- inc held high for 100 cycles → acc_out increments exactly once (0→1); one strobe only.
- Preload to 254 via 254 inc pulses, then 3 more inc with SATURATE=1 → 255, then stays 255; at_max=1, ovf=1; exactly one strobe after the 254 preload. Repeat with SATURATE=0 → 255, 0, 1; ovf=1; three strobes.
- From 0, dec with STEP=3 and SATURATE=0 → acc_out=253, ovf=1. Then clr → acc_out=0, ovf=0, one strobe.
- inc and dec rising in the same cycle from acc_out=5 → stays 5, no strobe. inc and clr together → 0.
- Two inc pulses one cycle apart → both counted (acc 0→2), two strobes. Assert rst during APPLY → all outputs at reset values, pending inc discarded.
